// File: rtl/mb_frame_reader.sv
// Word-level DMA reader: streams one YUV420 macroblock (64 Y, 16 U, 16 V words) from word-addressed SRAM.
// Optional macro MBR_RASTER_AUTO_EN: after each macroblock, advance in raster order without a new start.
module mb_frame_reader #(
  parameter int FRAME_W_MB = 22,
  parameter int FRAME_H_MB = 18,
  parameter int Y_BASE     = 0,
  parameter int U_BASE     = FRAME_W_MB * FRAME_H_MB * 64,
  parameter int V_BASE     = U_BASE + FRAME_W_MB * FRAME_H_MB * 16,
  parameter int MAX_OUT    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [5:0]  mb_x_i,
  input  logic [5:0]  mb_y_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        frame_done_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] data_word_o,
  output logic        data_valid_o,
  output logic [5:0]  cur_mb_x_o,
  output logic [5:0]  cur_mb_y_o
);

  localparam logic [31:0] Y_STRIDE  = 32'(FRAME_W_MB * 4);
  localparam logic [31:0] C_STRIDE  = 32'(FRAME_W_MB * 2);
  localparam logic [31:0] Y_BASE_W  = 32'(Y_BASE);
  localparam logic [31:0] U_BASE_W  = 32'(U_BASE);
  localparam logic [31:0] V_BASE_W  = 32'(V_BASE);
  localparam logic [6:0]  W_MB      = 7'(FRAME_W_MB);
  localparam logic [6:0]  H_MB      = 7'(FRAME_H_MB);
  localparam logic [3:0]  MAX_OUT_W = 4'(MAX_OUT);
  localparam logic [6:0]  LAST_RSP  = 7'd95;
`ifdef MBR_RASTER_AUTO_EN
  localparam logic [5:0]  LAST_X    = 6'(FRAME_W_MB - 1);
  localparam logic [5:0]  LAST_Y    = 6'(FRAME_H_MB - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    REQ_Y,
    REQ_U,
    REQ_V,
    DRAIN
  } state_t;

  state_t      state;
  logic [5:0]  req_cnt;
  logic [3:0]  outstanding;
  logic [6:0]  rsp_cnt;

  logic        in_req;
  logic        grant;
  logic        rsp_ok;
  logic        last_rsp;
  logic        in_range;
  logic        launch_auto;
  logic [31:0] y_row;
  logic [31:0] c_row;
  logic [31:0] y_addr;
  logic [31:0] c_addr;

`ifdef MBR_RASTER_AUTO_EN
  logic        auto_go;
  assign launch_auto = auto_go;
`else
  assign launch_auto = 1'b0;
`endif

  // Request/address generation depends only on registered state, so the address holds during a stall.
  always_comb begin
    in_req    = (state == REQ_Y) || (state == REQ_U) || (state == REQ_V);
    mem_req_o = in_req && (outstanding < MAX_OUT_W);
    grant     = mem_req_o && mem_gnt_i;
    rsp_ok    = mem_rvalid_i && (outstanding != 4'd0);
    last_rsp  = rsp_ok && (rsp_cnt == LAST_RSP);
    in_range  = ({1'b0, mb_x_i} < W_MB) && ({1'b0, mb_y_i} < H_MB);
    y_row     = 32'(cur_mb_y_o) * 32'd16 + 32'(req_cnt[5:2]);
    c_row     = 32'(cur_mb_y_o) * 32'd8 + 32'(req_cnt[4:1]);
    y_addr    = Y_BASE_W + y_row * Y_STRIDE + 32'(cur_mb_x_o) * 32'd4 + 32'(req_cnt[1:0]);
    c_addr    = c_row * C_STRIDE + 32'(cur_mb_x_o) * 32'd2 + 32'(req_cnt[0]);
    case (state)
      REQ_Y:   mem_addr_o = y_addr;
      REQ_U:   mem_addr_o = U_BASE_W + c_addr;
      REQ_V:   mem_addr_o = V_BASE_W + c_addr;
      default: mem_addr_o = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_cnt      <= '0;
      outstanding  <= '0;
      rsp_cnt      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      frame_done_o <= 1'b0;
      data_word_o  <= '0;
      data_valid_o <= 1'b0;
      cur_mb_x_o   <= '0;
      cur_mb_y_o   <= '0;
`ifdef MBR_RASTER_AUTO_EN
      auto_go      <= 1'b0;
`endif
    end else begin
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      frame_done_o <= 1'b0;
      data_valid_o <= 1'b0;

      case ({grant, rsp_ok})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: ;
      endcase

      // Responses arrive in order; one with nothing outstanding is stale and dropped.
      if (rsp_ok) begin
        data_word_o  <= mem_rdata_i;
        data_valid_o <= 1'b1;
        rsp_cnt      <= last_rsp ? 7'd0 : rsp_cnt + 7'd1;
      end

      case (state)
        IDLE: begin
          if (launch_auto) begin
`ifdef MBR_RASTER_AUTO_EN
            auto_go <= 1'b0;
`endif
            state <= REQ_Y;
          end else if (start_i) begin
            if (in_range) begin
              cur_mb_x_o <= mb_x_i;
              cur_mb_y_o <= mb_y_i;
              busy_o     <= 1'b1;
              state      <= REQ_Y;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        REQ_Y: begin
          if (grant) begin
            if (req_cnt == 6'd63) begin
              req_cnt <= '0;
              state   <= REQ_U;
            end else begin
              req_cnt <= req_cnt + 6'd1;
            end
          end
        end
        REQ_U: begin
          if (grant) begin
            if (req_cnt == 6'd15) begin
              req_cnt <= '0;
              state   <= REQ_V;
            end else begin
              req_cnt <= req_cnt + 6'd1;
            end
          end
        end
        REQ_V: begin
          if (grant) begin
            if (req_cnt == 6'd15) begin
              req_cnt <= '0;
              state   <= DRAIN;
            end else begin
              req_cnt <= req_cnt + 6'd1;
            end
          end
        end
        DRAIN: begin
          // Leaving on the final response lets a new start be taken in the done_o cycle.
          if (last_rsp) begin
            done_o <= 1'b1;
            state  <= IDLE;
`ifdef MBR_RASTER_AUTO_EN
            if (cur_mb_x_o == LAST_X && cur_mb_y_o == LAST_Y) begin
              frame_done_o <= 1'b1;
              busy_o       <= 1'b0;
              cur_mb_x_o   <= '0;
              cur_mb_y_o   <= '0;
            end else begin
              auto_go <= 1'b1;
              if (cur_mb_x_o == LAST_X) begin
                cur_mb_x_o <= '0;
                cur_mb_y_o <= cur_mb_y_o + 6'd1;
              end else begin
                cur_mb_x_o <= cur_mb_x_o + 6'd1;
              end
            end
`else
            busy_o <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mb_frame_reader.sv
// Self-checking bench for mb_frame_reader: randomized memory timing checked against an address/data model.
`timescale 1ns/1ps
module tb_mb_frame_reader;

`ifdef MBR_RASTER_AUTO_EN
  localparam int FW = 2;
  localparam int FH = 2;
`else
  localparam int FW = 22;
  localparam int FH = 18;
`endif
  localparam int YB   = 0;
  localparam int UB   = FW * FH * 64;
  localparam int VB   = UB + FW * FH * 16;
  localparam int MAXO = 4;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [5:0]  mb_x_i;
  logic [5:0]  mb_y_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        frame_done_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] data_word_o;
  logic        data_valid_o;
  logic [5:0]  cur_mb_x_o;
  logic [5:0]  cur_mb_y_o;

  mb_frame_reader #(
    .FRAME_W_MB(FW), .FRAME_H_MB(FH), .Y_BASE(YB), .U_BASE(UB), .V_BASE(VB), .MAX_OUT(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mb_x_i(mb_x_i), .mb_y_i(mb_y_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .frame_done_o(frame_done_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .data_word_o(data_word_o), .data_valid_o(data_valid_o),
    .cur_mb_x_o(cur_mb_x_o), .cur_mb_y_o(cur_mb_y_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  int          cyc = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] req_log[$];
  logic [31:0] data_log[$];
  logic [31:0] exp_q[$];
  int          done_pos[$];
  int          fdone_pos[$];
  int          err_pulses = 0;
  int          req_seen = 0;
  int          stable_viol = 0;
  int          max_pend = 0;
  int          stale_left = 0;
  bit          stall_en = 1'b0;
  int          max_lat = 1;
  logic        prev_req = 1'b0;
  logic        prev_gnt = 1'b0;
  logic        prev_rst = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // Address of word i of macroblock (x,y) in stream order, straight from the plane layout.
  function automatic logic [31:0] exp_addr(int x, int y, int i);
    int j;
    if (i < 64) return 32'(YB + (y * 16 + i / 4) * (FW * 4) + x * 4 + i % 4);
    j = (i < 80) ? i - 64 : i - 80;
    return 32'(((i < 80) ? UB : VB) + (y * 8 + j / 2) * (FW * 2) + x * 2 + j % 2);
  endfunction

  task automatic add_expected(input int x, input int y);
    for (int i = 0; i < 96; i++) exp_q.push_back(exp_addr(x, y, i));
  endtask

  // Memory model and output logger: grants, in-order delayed responses, protocol observations.
  always @(negedge clk) begin
    cyc++;
    if (data_valid_o) data_log.push_back(data_word_o);
    if (done_o) done_pos.push_back(data_valid_o ? data_log.size() : -1);
    if (frame_done_o) fdone_pos.push_back(done_o ? data_log.size() : -1);
    if (err_o) err_pulses++;
    if (mem_req_o) req_seen++;
    if (prev_rst && rst_n && prev_req && !prev_gnt && !(mem_req_o && mem_addr_o == prev_addr))
      stable_viol++;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
    end else if (stale_left > 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEAD_BEEF;
      stale_left--;
    end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    mem_gnt_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (rst_n && mem_req_o && mem_gnt_i) begin
      req_log.push_back(mem_addr_o);
      pend_addr.push_back(mem_addr_o);
      pend_due.push_back(cyc + (stall_en ? int'($urandom_range(1, max_lat)) : 1));
    end
    if (pend_addr.size() > max_pend) max_pend = pend_addr.size();
    prev_req  = mem_req_o;
    prev_gnt  = mem_gnt_i;
    prev_addr = mem_addr_o;
    prev_rst  = rst_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete();
    data_log.delete();
    exp_q.delete();
    done_pos.delete();
    fdone_pos.delete();
    err_pulses  = 0;
    req_seen    = 0;
    stable_viol = 0;
    max_pend    = 0;
  endtask

  task automatic launch(input int x, input int y);
    start_i = 1'b1;
    mb_x_i  = 6'(x);
    mb_y_i  = 6'(y);
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < budget && !ok) begin
      if (done_o) ok = 1'b1;
      else begin
        tick();
        cycles++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy_o, done_o, err_o, frame_done_o, mem_req_o, mem_addr_o, data_word_o, data_valid_o,
         cur_mb_x_o, cur_mb_y_o} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: busy=%b done=%b err=%b req=%b addr=%0d data=%h valid=%b x=%0d y=%0d (all required 0)",
               busy_o, done_o, err_o, mem_req_o, mem_addr_o, data_word_o, data_valid_o, cur_mb_x_o, cur_mb_y_o);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy_o, mem_req_o} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: busy=%b req=%b required 0 0", busy_o, mem_req_o);
    end
  endtask

  task automatic test_error();
    int x, y;
    clear_logs();
    for (int k = 0; k < 2; k++) begin
      x = (k == 0) ? FW : 0;
      y = (k == 0) ? 0 : FH;
      launch(x, y);
      checks++;
      if ({err_o, busy_o} !== 2'b10) begin
        fails++;
        $display("[TB] FAIL err_pulse(%0d,%0d): err=%b busy=%b required err=1 busy=0", x, y, err_o, busy_o);
      end
      tick();
      checks++;
      if (err_o !== 1'b0) begin
        fails++;
        $display("[TB] FAIL err_width(%0d,%0d): err=%b required 0 one cycle later", x, y, err_o);
      end
    end
    repeat (5) tick();
    checks++;
    if (req_seen != 0 || err_pulses != 2 || busy_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL err_no_activity: req_cycles=%0d err_pulses=%0d busy=%b required 0 2 0",
               req_seen, err_pulses, busy_o);
    end
  endtask

`ifndef MBR_RASTER_AUTO_EN
  task automatic test_basic();
    int cycles, nerr;
    bit ok;
    logic [159:0] lits;
    clear_logs();
    add_expected(0, 0);
    launch(0, 0);
    wait_done(400, cycles, ok);
    checks++;
    if (!ok || cycles != 97) begin
      fails++;
      $display("[TB] FAIL basic_latency: done after %0d cycles (seen=%0d) required 97", cycles, ok);
    end
    repeat (3) tick();
    lits = (req_log.size() >= 96) ? {req_log[1], req_log[4], req_log[64], req_log[66], req_log[80]} : '1;
    checks++;
    if (lits !== {32'd1, 32'd88, 32'd25344, 32'd25388, 32'd31680}) begin
      fails++;
      $display("[TB] FAIL basic_addr_points: got %h required addrs 1,88,25344,25388,31680", lits);
    end
    nerr = 0;
    for (int i = 0; i < 96; i++)
      if (i >= req_log.size() || req_log[i] !== exp_q[i] || i >= data_log.size() || data_log[i] !== mem_word(exp_q[i])) nerr++;
    checks++;
    if (nerr != 0 || req_log.size() != 96 || data_log.size() != 96) begin
      fails++;
      $display("[TB] FAIL basic_stream: %0d bad words, %0d reqs, %0d data, required 0 96 96", nerr, req_log.size(), data_log.size());
    end
    checks++;
    if (done_pos.size() != 1 || done_pos[0] != 96 || busy_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_done: %0d done pulses, busy=%b, required one pulse with word 96 and busy 0", done_pos.size(), busy_o);
    end
  endtask

  task automatic test_position();
    int cycles, nerr;
    bit ok;
    logic [127:0] pts;
    clear_logs();
    add_expected(1, 2);
    launch(1, 2);
    wait_done(400, cycles, ok);
    repeat (3) tick();
    pts = (req_log.size() >= 96) ? {req_log[0], req_log[63], req_log[64], req_log[80]} : '1;
    checks++;
    if (pts !== {32'd2820, exp_addr(1, 2, 63), 32'd26050, 32'd32386}) begin
      fails++;
      $display("[TB] FAIL pos_addr_points: got %h required 2820,%0d,26050,32386", pts, exp_addr(1, 2, 63));
    end
    nerr = 0;
    for (int i = 0; i < 96; i++)
      if (i >= data_log.size() || data_log[i] !== mem_word(exp_q[i])) nerr++;
    checks++;
    if (!ok || nerr != 0 || done_pos.size() != 1) begin
      fails++;
      $display("[TB] FAIL pos_stream: done=%0d bad data=%0d done pulses=%0d required 1 0 1", ok, nerr, done_pos.size());
    end
  endtask

  task automatic test_back_to_back();
    int cycles, nerr;
    bit ok;
    clear_logs();
    add_expected(21, 17);
    add_expected(4, 9);
    launch(21, 17);
    wait_done(400, cycles, ok);
    launch(4, 9);
    checks++;
    if ({busy_o, cur_mb_x_o, cur_mb_y_o} !== {1'b1, 6'd4, 6'd9}) begin
      fails++;
      $display("[TB] FAIL b2b_accept: busy=%b x=%0d y=%0d required 1 4 9", busy_o, cur_mb_x_o, cur_mb_y_o);
    end
    wait_done(400, cycles, ok);
    repeat (3) tick();
    nerr = 0;
    for (int i = 0; i < 192; i++)
      if (i >= req_log.size() || req_log[i] !== exp_q[i] || i >= data_log.size() || data_log[i] !== mem_word(exp_q[i])) nerr++;
    checks++;
    if (!ok || cycles != 97 || nerr != 0) begin
      fails++;
      $display("[TB] FAIL b2b_stream: done=%0d latency=%0d bad words=%0d required 1 97 0", ok, cycles, nerr);
    end
    checks++;
    if (done_pos.size() != 2 || done_pos[0] != 96 || done_pos[1] != 192) begin
      fails++;
      $display("[TB] FAIL b2b_done: %0d pulses required 2 at words 96 and 192", done_pos.size());
    end
  endtask

  task automatic test_random();
    int cycles, nerr, x, y;
    bit ok;
    stall_en = 1'b1;
    max_lat  = 5;
    for (int t = 0; t < 3; t++) begin
      x = $urandom_range(0, FW - 1);
      y = $urandom_range(0, FH - 1);
      clear_logs();
      add_expected(x, y);
      launch(x, y);
      repeat (10) tick();
      launch((x + 1) % FW, (y + 1) % FH);
      checks++;
      if ({cur_mb_x_o, cur_mb_y_o} !== {6'(x), 6'(y)} || err_pulses != 0) begin
        fails++;
        $display("[TB] FAIL rand_busy_start: x=%0d y=%0d err=%0d required %0d %0d 0", cur_mb_x_o, cur_mb_y_o, err_pulses, x, y);
      end
      wait_done(3000, cycles, ok);
      repeat (8) tick();
      nerr = 0;
      for (int i = 0; i < 96; i++)
        if (i >= req_log.size() || req_log[i] !== exp_q[i] || i >= data_log.size() || data_log[i] !== mem_word(exp_q[i])) nerr++;
      checks++;
      if (!ok || nerr != 0 || data_log.size() != 96) begin
        fails++;
        $display("[TB] FAIL rand_stream(%0d,%0d): done=%0d bad words=%0d data=%0d required 1 0 96", x, y, ok, nerr, data_log.size());
      end
      checks++;
      if (max_pend > MAXO || stable_viol != 0) begin
        fails++;
        $display("[TB] FAIL rand_protocol(%0d,%0d): max outstanding=%0d addr-stall violations=%0d required <=%0d 0", x, y, max_pend, stable_viol, MAXO);
      end
      checks++;
      if (done_pos.size() != 1 || done_pos[0] != 96) begin
        fails++;
        $display("[TB] FAIL rand_done(%0d,%0d): %0d pulses required one with word 96", x, y, done_pos.size());
      end
    end
    stall_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cycles, n0, nerr, guard;
    bit ok;
    clear_logs();
    launch(5, 4);
    guard = 0;
    while (data_log.size() < 40 && guard < 400) begin
      tick();
      guard++;
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (data_log.size() < 40 || {busy_o, done_o, err_o, mem_req_o, mem_addr_o, data_valid_o, data_word_o, cur_mb_x_o} !== '0) begin
      fails++;
      $display("[TB] FAIL midreset_outputs: words=%0d busy=%b req=%b addr=%0d valid=%b x=%0d required >=40 and all 0",
               data_log.size(), busy_o, mem_req_o, mem_addr_o, data_valid_o, cur_mb_x_o);
    end
    tick();
    rst_n = 1'b1;
    n0 = data_log.size();
    stale_left = 2;
    repeat (4) tick();
    checks++;
    if (data_log.size() != n0 || busy_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL stale_rvalid: %0d extra words busy=%b required 0 0", data_log.size() - n0, busy_o);
    end
    clear_logs();
    add_expected(3, 3);
    launch(3, 3);
    wait_done(400, cycles, ok);
    repeat (3) tick();
    nerr = 0;
    for (int i = 0; i < 96; i++)
      if (i >= req_log.size() || req_log[i] !== exp_q[i] || i >= data_log.size() || data_log[i] !== mem_word(exp_q[i])) nerr++;
    checks++;
    if (!ok || nerr != 0 || data_log.size() != 96 || done_pos.size() != 1) begin
      fails++;
      $display("[TB] FAIL after_reset_stream: done=%0d bad=%0d data=%0d pulses=%0d required 1 0 96 1", ok, nerr, data_log.size(), done_pos.size());
    end
  endtask
`else
  task automatic test_raster();
    int guard, nerr;
    clear_logs();
    add_expected(0, 0);
    add_expected(1, 0);
    add_expected(0, 1);
    add_expected(1, 1);
    launch(0, 0);
    guard = 0;
    while (done_pos.size() < 4 && guard < 2000) begin
      tick();
      guard++;
    end
    repeat (5) tick();
    nerr = 0;
    for (int i = 0; i < 384; i++)
      if (i >= req_log.size() || req_log[i] !== exp_q[i] || i >= data_log.size() || data_log[i] !== mem_word(exp_q[i])) nerr++;
    checks++;
    if (nerr != 0 || req_log.size() != 384 || data_log.size() != 384) begin
      fails++;
      $display("[TB] FAIL raster_stream: bad=%0d reqs=%0d data=%0d required 0 384 384", nerr, req_log.size(), data_log.size());
    end
    checks++;
    if (done_pos.size() != 4 || done_pos[0] != 96 || done_pos[1] != 192 || done_pos[2] != 288 || done_pos[3] != 384) begin
      fails++;
      $display("[TB] FAIL raster_done: %0d pulses required 4 at words 96,192,288,384", done_pos.size());
    end
    checks++;
    if (fdone_pos.size() != 1 || fdone_pos[0] != 384) begin
      fails++;
      $display("[TB] FAIL raster_frame_done: %0d pulses required one with the 4th done", fdone_pos.size());
    end
    checks++;
    if ({busy_o, mem_req_o, cur_mb_x_o, cur_mb_y_o} !== '0) begin
      fails++;
      $display("[TB] FAIL raster_end_idle: busy=%b req=%b x=%0d y=%0d required 0 0 0 0", busy_o, mem_req_o, cur_mb_x_o, cur_mb_y_o);
    end
  endtask
`endif

  initial begin
    rst_n        = 1'b0;
    start_i      = 1'b0;
    mb_x_i       = '0;
    mb_y_i       = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    test_reset();
    test_error();
`ifndef MBR_RASTER_AUTO_EN
    test_basic();
    test_position();
    test_back_to_back();
    test_random();
    test_reset_mid();
`else
    test_raster();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
